// File: rtl/calc_pkg.sv
// Shared definitions for the calculator sequencer: op encodings, FSM states
// and the multiply iteration count.
package calc_pkg;

    localparam logic [1:0]  OP_ADD8   = 2'b00;
    localparam logic [1:0]  OP_MUL4   = 2'b01;

    localparam int unsigned MUL_ITERS = 4;
    localparam int unsigned CNT_W     = 2;
    localparam int unsigned NIB_W     = 4;
    localparam int unsigned BYTE_W    = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADD_LO = 3'd1,
        ST_ADD_HI = 3'd2,
        ST_ADD_CI = 3'd3,
        ST_MUL_IT = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

endpackage

// File: rtl/calc_seq_dp.sv
// Datapath for calc_seq_ctrl: operand, temp and accumulator registers plus the
// adder operand mux decoded from the current state.
// Ports:
//   Clk, Rst       clock, async active-high reset
//   i_state        current FSM state
//   i_load         operand capture (accepted Start)
//   i_a, i_b       operands from the keypad registers
//   i_adr_s/cry    combinational sum/carry from the shared 4-bit adder
//   o_adr_a_c/b_c  adder operands (combinational from state)
//   o_c1           carry out of the high-nibble add
//   o_mul_prod_c   {H,Q} after the current multiply iteration
module calc_seq_dp
    import calc_pkg::*;
(
    input  logic                Clk,
    input  logic                Rst,
    input  state_t              i_state,
    input  logic                i_load,
    input  logic [BYTE_W-1:0]   i_a,
    input  logic [BYTE_W-1:0]   i_b,
    input  logic [NIB_W-1:0]    i_adr_s,
    input  logic                i_adr_cry,
    output logic [NIB_W-1:0]    o_adr_a_c,
    output logic [NIB_W-1:0]    o_adr_b_c,
    output logic                o_c1,
    output logic [BYTE_W-1:0]   o_mul_prod_c
);

    logic [BYTE_W-1:0] r_a;
    logic [BYTE_W-1:0] r_b;
    logic [NIB_W-1:0]  r_t;
    logic              r_c0;
    logic              r_c1;
    logic [NIB_W-1:0]  r_h;
    logic [NIB_W-1:0]  r_q;

    logic [BYTE_W-1:0] w_mul_prod;

    // Shift-add step: new accumulator in the top, multiplier shifted right.
    assign w_mul_prod   = {i_adr_cry, i_adr_s, r_q[NIB_W-1:1]};
    assign o_mul_prod_c = w_mul_prod;
    assign o_c1         = r_c1;

    // Register updates per arithmetic state.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_a  <= '0;
            r_b  <= '0;
            r_t  <= '0;
            r_c0 <= 1'b0;
            r_c1 <= 1'b0;
            r_h  <= '0;
            r_q  <= '0;
        end else if (i_load) begin
            r_a  <= i_a;
            r_b  <= i_b;
            r_t  <= '0;
            r_c0 <= 1'b0;
            r_c1 <= 1'b0;
            r_h  <= '0;
            r_q  <= i_b[NIB_W-1:0];
        end else begin
            case (i_state)
                ST_ADD_LO: r_c0 <= i_adr_cry;
                ST_ADD_HI: begin
                    r_t  <= i_adr_s;
                    r_c1 <= i_adr_cry;
                end
                ST_MUL_IT: {r_h, r_q} <= w_mul_prod;
                default: ;
            endcase
        end
    end

    // Adder operand mux; zero in non-arithmetic states.
    always_comb begin
        o_adr_a_c = '0;
        o_adr_b_c = '0;
        case (i_state)
            ST_ADD_LO: begin
                o_adr_a_c = r_a[NIB_W-1:0];
                o_adr_b_c = r_b[NIB_W-1:0];
            end
            ST_ADD_HI: begin
                o_adr_a_c = r_a[BYTE_W-1:NIB_W];
                o_adr_b_c = r_b[BYTE_W-1:NIB_W];
            end
            ST_ADD_CI: begin
                o_adr_a_c = r_t;
                o_adr_b_c = {3'b000, r_c0};
            end
            ST_MUL_IT: begin
                o_adr_a_c = r_h;
                o_adr_b_c = r_q[0] ? r_a[NIB_W-1:0] : 4'h0;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/calc_seq_ctrl.sv
// Multi-cycle sequencer sharing one external 4-bit adder for 8-bit add and
// 4x4 shift-add multiply.
// Ports:
//   Clk, Rst        clock, async active-high reset
//   Start, Op, A, B request, opcode (00 add8, 01 mul4, 1x reserved), operands
//   AdrA, AdrB      operands to the adder (decoded from state)
//   AdrS, AdrCry    combinational sum/carry from the adder
//   Result, Cry     8-bit result and add carry, held until next accepted Start
//   Err             reserved opcode accepted
//   Busy            high in every non-idle state
//   Done            one-cycle completion pulse
module calc_seq_ctrl
    import calc_pkg::*;
(
    input  logic                Clk,
    input  logic                Rst,
    input  logic                Start,
    input  logic [1:0]          Op,
    input  logic [BYTE_W-1:0]   A,
    input  logic [BYTE_W-1:0]   B,
    output logic [NIB_W-1:0]    AdrA,
    output logic [NIB_W-1:0]    AdrB,
    input  logic [NIB_W-1:0]    AdrS,
    input  logic                AdrCry,
    output logic [BYTE_W-1:0]   Result,
    output logic                Cry,
    output logic                Err,
    output logic                Busy,
    output logic                Done
);

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [BYTE_W-1:0]  r_result;
    logic [BYTE_W-1:0]  w_result_nxt;
    logic               r_cry;
    logic               w_cry_nxt;
    logic               r_err;
    logic               w_err_nxt;
    logic               r_busy;
    logic               r_done;
    logic               w_load;
    logic               w_c1;
    logic [BYTE_W-1:0]  w_mul_prod;

    calc_seq_dp u_dp (
        .Clk          (Clk),
        .Rst          (Rst),
        .i_state      (r_state),
        .i_load       (w_load),
        .i_a          (A),
        .i_b          (B),
        .i_adr_s      (AdrS),
        .i_adr_cry    (AdrCry),
        .o_adr_a_c    (AdrA),
        .o_adr_b_c    (AdrB),
        .o_c1         (w_c1),
        .o_mul_prod_c (w_mul_prod)
    );

    // State and registered outputs.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_result <= '0;
            r_cry    <= 1'b0;
            r_err    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_cnt    <= w_cnt_nxt;
            r_result <= w_result_nxt;
            r_cry    <= w_cry_nxt;
            r_err    <= w_err_nxt;
            r_busy   <= (w_next != ST_IDLE);
            r_done   <= (w_next == ST_DONE);
        end
    end

    // Next state and next values of the result registers.
    always_comb begin
        w_next       = r_state;
        w_cnt_nxt    = r_cnt;
        w_result_nxt = r_result;
        w_cry_nxt    = r_cry;
        w_err_nxt    = r_err;
        w_load       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (Start) begin
                    w_load       = 1'b1;
                    w_result_nxt = '0;
                    w_cry_nxt    = 1'b0;
                    w_err_nxt    = 1'b0;
                    case (Op)
                        OP_ADD8: w_next = ST_ADD_LO;
                        OP_MUL4: begin
                            w_next    = ST_MUL_IT;
                            w_cnt_nxt = '0;
                        end
                        default: begin
                            w_err_nxt = 1'b1;
                            w_next    = ST_DONE;
                        end
                    endcase
                end
            end
            ST_ADD_LO: begin
                w_result_nxt[NIB_W-1:0] = AdrS;
                w_next                  = ST_ADD_HI;
            end
            ST_ADD_HI: w_next = ST_ADD_CI;
            ST_ADD_CI: begin
                // Always runs so add latency is fixed; carries are exclusive.
                w_result_nxt[BYTE_W-1:NIB_W] = AdrS;
                w_cry_nxt                    = w_c1 | AdrCry;
                w_next                       = ST_DONE;
            end
            ST_MUL_IT: begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (r_cnt == CNT_W'(MUL_ITERS - 1)) begin
                    w_result_nxt = w_mul_prod;
                    w_next       = ST_DONE;
                end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    assign Result = r_result;
    assign Cry    = r_cry;
    assign Err    = r_err;
    assign Busy   = r_busy;
    assign Done   = r_done;

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Directed self-checking bench for calc_seq_ctrl with a behavioural 4-bit adder.
module tb_calc_seq_ctrl;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       Start;
    logic [1:0] Op;
    logic [7:0] A;
    logic [7:0] B;
    logic [3:0] AdrA;
    logic [3:0] AdrB;
    logic [3:0] AdrS;
    logic       AdrCry;
    logic [7:0] Result;
    logic       Cry;
    logic       Err;
    logic       Busy;
    logic       Done;

    int checks   = 0;
    int failures = 0;
    int done_cnt;

    always #5 Clk = ~Clk;

    // Stand-in for the external Adr4Bit.
    assign {AdrCry, AdrS} = 5'(AdrA) + 5'(AdrB);

    calc_seq_ctrl dut (
        .Clk    (Clk),
        .Rst    (Rst),
        .Start  (Start),
        .Op     (Op),
        .A      (A),
        .B      (B),
        .AdrA   (AdrA),
        .AdrB   (AdrB),
        .AdrS   (AdrS),
        .AdrCry (AdrCry),
        .Result (Result),
        .Cry    (Cry),
        .Err    (Err),
        .Busy   (Busy),
        .Done   (Done)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a request sampled at the next rising edge (edge N); returns at
    // the falling edge inside cycle N+1 with operands scrambled.
    task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        @(negedge Clk);
        Start = 1'b1;
        Op    = op;
        A     = a;
        B     = b;
        @(negedge Clk);
        Start = 1'b0;
        A     = 8'hA5;
        B     = 8'h5A;
    endtask

    // Issue a request and check Busy/Done timing, first-cycle adder operands,
    // final result and the return to idle.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [7:0] a,
                          input logic [7:0] b, input int lat, input logic [7:0] exp_res,
                          input logic exp_cry, input logic exp_err);
        issue(op, a, b);
        if (op == 2'b00) begin
            chk({tag, "_adra_lo"}, 8'(AdrA), 8'(a[3:0]));
            chk({tag, "_adrb_lo"}, 8'(AdrB), 8'(b[3:0]));
        end else if (op == 2'b01) begin
            chk({tag, "_adra_m0"}, 8'(AdrA), 8'h00);
            chk({tag, "_adrb_m0"}, 8'(AdrB), b[0] ? 8'(a[3:0]) : 8'h00);
        end
        for (int k = 1; k <= lat; k++) begin
            if (k > 1) @(negedge Clk);
            chk($sformatf("%s_busy_c%0d", tag, k), 8'(Busy), 8'h01);
            chk($sformatf("%s_done_c%0d", tag, k), 8'(Done), (k == lat) ? 8'h01 : 8'h00);
        end
        chk({tag, "_result"}, Result, exp_res);
        chk({tag, "_cry"}, 8'(Cry), 8'(exp_cry));
        chk({tag, "_err"}, 8'(Err), 8'(exp_err));
        @(negedge Clk);
        chk({tag, "_busy_after"}, 8'(Busy), 8'h00);
        chk({tag, "_done_after"}, 8'(Done), 8'h00);
        chk({tag, "_result_held"}, Result, exp_res);
    endtask

    initial begin
        Rst   = 1'b1;
        Start = 1'b0;
        Op    = 2'b00;
        A     = 8'h00;
        B     = 8'h00;
        #1;
        chk("rst_result", Result, 8'h00);
        chk("rst_busy", 8'(Busy), 8'h00);
        chk("rst_done", 8'(Done), 8'h00);
        chk("rst_err", 8'(Err), 8'h00);
        chk("rst_adra", 8'(AdrA), 8'h00);
        repeat (2) @(negedge Clk);
        Rst = 1'b0;
        @(negedge Clk);
        chk("idle_adrb", 8'(AdrB), 8'h00);

        run_op("add_3c_48", 2'b00, 8'h3C, 8'h48, 4, 8'h84, 1'b0, 1'b0);
        run_op("add_ff_01", 2'b00, 8'hFF, 8'h01, 4, 8'h00, 1'b1, 1'b0);
        run_op("add_80_80", 2'b00, 8'h80, 8'h80, 4, 8'h00, 1'b1, 1'b0);
        run_op("mul_d_b",   2'b01, 8'h0D, 8'h0B, 5, 8'h8F, 1'b0, 1'b0);
        run_op("mul_f_f",   2'b01, 8'h0F, 8'h0F, 5, 8'hE1, 1'b0, 1'b0);
        run_op("mul_hi_ign", 2'b01, 8'hE6, 8'h97, 5, 8'h2A, 1'b0, 1'b0);

        // Start while busy is ignored: one Done at N+4 only.
        issue(2'b00, 8'h10, 8'h20);
        Start = 1'b1;
        Op    = 2'b01;
        A     = 8'h0F;
        B     = 8'h0F;
        done_cnt = 0;
        for (int k = 2; k <= 10; k++) begin
            @(negedge Clk);
            Start = 1'b0;
            if (Done) done_cnt++;
            if (k == 4) chk("ign_done_n4", 8'(Done), 8'h01);
            if (k == 4) chk("ign_result", Result, 8'h30);
        end
        chk("ign_done_count", 8'(done_cnt), 8'h01);
        chk("ign_busy_end", 8'(Busy), 8'h00);

        // Asynchronous reset mid-multiply.
        issue(2'b01, 8'h0D, 8'h0B);
        @(posedge Clk);
        #2 Rst = 1'b1;
        #1;
        chk("arst_busy", 8'(Busy), 8'h00);
        chk("arst_result", Result, 8'h00);
        chk("arst_done", 8'(Done), 8'h00);
        chk("arst_adra", 8'(AdrA), 8'h00);
        #1 Rst = 1'b0;
        done_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge Clk);
            if (Done) done_cnt++;
        end
        chk("arst_no_done", 8'(done_cnt), 8'h00);
        run_op("add_01_01", 2'b00, 8'h01, 8'h01, 4, 8'h02, 1'b0, 1'b0);

        // Reserved opcode, then a valid add clears Err.
        run_op("rsv_op10", 2'b10, 8'h12, 8'h34, 1, 8'h00, 1'b0, 1'b1);
        run_op("rsv_op11", 2'b11, 8'h56, 8'h78, 1, 8'h00, 1'b0, 1'b1);
        run_op("add_clr_err", 2'b00, 8'h21, 8'h12, 4, 8'h33, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
